// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, reset vector, fetch entry and fetch FSM state types
package pipe_pkg;
  localparam int PC_W = 30;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = 30'h0000C0D;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus (req/addr/gnt out, rvalid/rdata back), master = fetch side
interface fetch_unit_if;
  import pipe_pkg::*;
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry fetch queue; i_push/i_pop/i_clear in, o_data head, o_count, o_empty out
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = r_cnt == '0;
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, imem requests (imem master), in-order response queue, ID register (id_*_o)
module fetch_unit
  import pipe_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  fetch_unit_if.master       imem,
  output logic               id_valid_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [PC_W-1:0]    id_pc_plus1_o,
  output logic [INSTR_W-1:0] id_instr_o
);
  localparam int CW = $clog2(DEPTH) + 2;
  fetch_state_t    r_state, w_state_n;
  logic [PC_W-1:0] r_fetch_pc, r_resp_pc, w_restart_pc;
  logic [CW-1:0]   r_out, r_drop, w_out_n, w_drop_n;
  logic [CW-2:0]   w_count;
  logic            r_rst_q, w_req, w_hs, w_flush, w_stale, w_push, w_pop, w_empty;
  fetch_entry_t    w_entry, w_head;
  // stale responses still owed (r_drop) also occupy request slots, so in-flight traffic stays bounded
  assign w_req = r_state == RUN && !redirect_i && !rst && !r_rst_q &&
                 ({1'b0, w_count} + r_out + r_drop) < CW'(DEPTH);
  assign imem.req      = w_req;
  assign imem.addr     = r_fetch_pc;
  assign w_hs          = w_req && imem.gnt;
  assign w_flush       = rst || redirect_i;
  assign w_restart_pc  = rst ? RESET_PC : redirect_pc_i;
  assign w_stale       = imem.rvalid && r_drop != '0;
  assign w_push        = imem.rvalid && r_drop == '0 && !w_flush;
  assign w_pop         = !w_empty && !stall_i && !w_flush;
  assign w_entry       = '{pc: r_resp_pc, instr: imem.rdata};
  assign id_pc_plus1_o = id_pc_o + 1'b1;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_clear(redirect_i),
    .i_data(w_entry), .o_data(w_head), .o_count(w_count), .o_empty(w_empty)
  );
  // reset and redirect both turn everything still in flight into responses to discard
  always_comb begin
    w_out_n   = w_flush ? '0 : r_out + CW'(w_hs) - CW'(w_push);
    w_drop_n  = w_flush ? r_out + r_drop - CW'(imem.rvalid) : r_drop - CW'(w_stale);
    w_state_n = redirect_i ? (w_drop_n != '0 ? DRAIN : RUN) :
                (r_state == DRAIN && w_drop_n == '0) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else r_state <= w_state_n;
  end
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    r_out   <= w_out_n;
    r_drop  <= w_drop_n;
    if (w_flush) begin
      r_fetch_pc <= w_restart_pc;
      r_resp_pc  <= w_restart_pc;
    end else begin
      if (w_hs) r_fetch_pc <= r_fetch_pc + 1'b1;
      if (w_push) r_resp_pc <= r_resp_pc + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_o <= 1'b0;
      id_pc_o    <= '0;
      id_instr_o <= '0;
    end else if (redirect_i) begin
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      id_valid_o <= !w_empty;
      if (!w_empty) begin
        id_pc_o    <= w_head.pc;
        id_instr_o <= w_head.instr;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random/directed stimulus, imem model, scoreboard of expected ID instruction stream
module tb_fetch_unit;
  import pipe_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic               rst, stall_i, redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               id_valid_o;
  logic [PC_W-1:0]    id_pc_o, id_pc_plus1_o;
  logic [INSTR_W-1:0] id_instr_o;
  fetch_unit_if imem();
  fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem(imem), .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o), .id_pc_plus1_o(id_pc_plus1_o), .id_instr_o(id_instr_o)
  );
  int n_chk = 0, n_err = 0, n_got = 0, cyc = 0, hs_edge = -1;
  bit t1_arm = 1'b0;
  logic [PC_W-1:0]    exp_q[$];
  logic [INSTR_W-1:0] pend[$];
  logic [PC_W-1:0]    req_pc;
  logic s_rst, s_stall, s_redir, g_en, g_rand, rv_en, rv_rand;
  logic [PC_W-1:0] s_rpc;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] pc);
    return {pc, 2'b11} ^ 32'h9E3779B9;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic restart(input logic [PC_W-1:0] pc);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(pc + PC_W'(i));
    req_pc = pc;
  endtask
  task automatic step();
    bit last_rst;
    @(negedge clk);
    last_rst = rst;
    rst = s_rst;
    stall_i = s_stall;
    redirect_i = s_redir;
    redirect_pc_i = s_rpc;
    #1;
    if (last_rst) check("req_after_reset", 64'(imem.req), 64'(0));
    if (redirect_i) check("req_during_redirect", 64'(imem.req), 64'(0));
    imem.gnt = g_en && (!g_rand || $urandom_range(3) != 0);
    imem.rvalid = 1'b0;
    imem.rdata = $urandom;
    if (rv_en && pend.size() > 0 && (!rv_rand || $urandom_range(2) != 0)) begin
      imem.rvalid = 1'b1;
      imem.rdata = pend.pop_front();
    end
    if (imem.req && imem.gnt) begin
      check("req_addr", 64'(imem.addr), 64'(req_pc));
      pend.push_back(mem_word(imem.addr));
      req_pc = req_pc + 1'b1;
      if (t1_arm && hs_edge < 0) hs_edge = cyc + 1;
    end
    if (rst) restart(RESET_PC);
    else if (redirect_i) restart(redirect_pc_i);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  initial begin
    logic               h_valid;
    logic [PC_W-1:0]    h_pc, e_pc;
    logic [INSTR_W-1:0] h_instr;
    h_valid = 1'b0;
    h_pc = '0;
    h_instr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        check("reset_valid", 64'(id_valid_o), 64'(0));
        check("reset_pc", 64'(id_pc_o), 64'(0));
        check("reset_instr", 64'(id_instr_o), 64'(0));
      end else if (redirect_i) begin
        check("redirect_bubble", 64'(id_valid_o), 64'(0));
      end else if (stall_i) begin
        check("stall_hold", 64'({id_valid_o, id_pc_o, id_instr_o}), 64'({h_valid, h_pc, h_instr}));
      end else if (id_valid_o) begin
        check("stream_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e_pc = exp_q.pop_front();
          check("id_pc", 64'(id_pc_o), 64'(e_pc));
          check("id_pc_plus1", 64'(id_pc_plus1_o), 64'(PC_W'(e_pc + 1'b1)));
          check("id_instr", 64'(id_instr_o), 64'(mem_word(e_pc)));
          n_got++;
          if (t1_arm) begin
            check("first_latency", 64'(cyc), 64'(hs_edge + 2));
            t1_arm = 1'b0;
          end
        end
      end
      h_valid = id_valid_o;
      h_pc = id_pc_o;
      h_instr = id_instr_o;
    end
  end
  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    s_rst = 1'b1; s_stall = 1'b0; s_redir = 1'b0; s_rpc = '0;
    g_en = 1'b1; g_rand = 1'b0; rv_en = 1'b1; rv_rand = 1'b0;
    restart(RESET_PC);
    run(3);
    s_rst = 1'b0; t1_arm = 1'b1; hs_edge = -1;
    run(12);
    check("first_instr_seen", 64'(t1_arm), 64'(0));
    s_stall = 1'b1;
    run(4);
    check("stall_backpressure", 64'(imem.req), 64'(0));
    s_stall = 1'b0;
    run(10);
    rv_en = 1'b0;
    run(4);
    s_redir = 1'b1; s_rpc = 30'h100;
    run(1);
    s_redir = 1'b0;
    run(1);
    check("drain_no_req", 64'(imem.req), 64'(0));
    rv_en = 1'b1;
    run(15);
    s_stall = 1'b1;
    run(1);
    s_redir = 1'b1; s_rpc = 30'h2A0;
    run(1);
    s_redir = 1'b0; s_stall = 1'b0;
    run(15);
    s_redir = 1'b1; s_rpc = 30'h3FFFFFFF;
    run(1);
    s_redir = 1'b0;
    run(15);
    rv_en = 1'b0;
    run(4);
    s_redir = 1'b1; s_rpc = 30'h200;
    run(1);
    s_redir = 1'b0; rv_en = 1'b1;
    run(1);
    rv_en = 1'b0; s_rst = 1'b1;
    run(2);
    s_rst = 1'b0;
    run(2);
    rv_en = 1'b1;
    run(15);
    g_rand = 1'b1; rv_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      s_stall = $urandom_range(3) == 0;
      s_redir = $urandom_range(29) == 0;
      s_rpc = ($urandom_range(3) == 0) ? 30'h3FFFFFF0 + PC_W'($urandom_range(31)) : PC_W'($urandom);
      s_rst = $urandom_range(199) == 0;
      run(1);
    end
    s_stall = 1'b0; s_redir = 1'b0; s_rst = 1'b0;
    run(30);
    check("progress", 64'(n_got > 300), 64'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
